oled_rect_sched: RTL and testbench

OLED_RECT_SCHED -- requirements
Module: oled_rect_sched

---
 rtl/oled_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 38 +++
 rtl/oled_rect_sched.sv | 201 ++++++++++++++++++++
 tb/tb_oled_rect_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared ST7735 opcodes, default panel geometry and the rectangle scheduler state encoding.
package oled_pkg;

  localparam logic [7:0] CmdCaset = 8'h2A;
  localparam logic [7:0] CmdRaset = 8'h2B;
  localparam logic [7:0] CmdRamwr = 8'h2C;

  localparam int unsigned DefXSize = 160;
  localparam int unsigned DefYSize = 80;

  typedef enum logic [2:0] {
    StIdle,
    StCaset,
    StRaset,
    StRamwr,
    StPixel,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Index of the requester favoured on the next tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && (|req_i)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/oled_rect_sched.sv
// Fill-rectangle scheduler: arbitrates two requesters and emits CASET/RASET/RAMWR plus pixel bytes.
module oled_rect_sched
  import oled_pkg::*;
#(
  parameter int unsigned C_x_size   = DefXSize,
  parameter int unsigned C_y_size   = DefYSize,
  parameter int unsigned C_x_offset = 0,
  parameter int unsigned C_y_offset = 0
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        init_done,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_x0,
  input  logic [15:0] req_x1,
  input  logic [13:0] req_y0,
  input  logic [13:0] req_y1,
  input  logic [31:0] req_color,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic        err
);

  state_e state_q, state_d;

  logic [7:0]  x0_q, x0_d, x1_q, x1_d;
  logic [6:0]  y0_q, y0_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;
  logic        id_q, id_d;
  logic [2:0]  idx_q, idx_d;
  logic [13:0] pix_q, pix_d;
  logic        lo_q, lo_d;

  logic [1:0]  gnt;
  logic        acc, sel, bad, hs, last_arg;
  logic [7:0]  sel_x0, sel_x1;
  logic [6:0]  sel_y0, sel_y1;
  logic [15:0] sel_color;
  logic [15:0] xs, xe, ys, ye, w0, w1;
  logic [13:0] width, height;

  // resn gates the accept so req_ready reads 0 while reset is held.
  assign acc = resn & init_done & (state_q == StIdle) & (|req_valid);

  rr_arb2 u_arb (
    .clk_i  (clk),
    .rst_ni (resn),
    .req_i  (req_valid),
    .en_i   (acc),
    .gnt_o  (gnt)
  );

  assign req_ready = acc ? gnt : 2'b00;
  assign sel       = gnt[1];
  assign sel_x0    = sel ? req_x0[15:8]     : req_x0[7:0];
  assign sel_x1    = sel ? req_x1[15:8]     : req_x1[7:0];
  assign sel_y0    = sel ? req_y0[13:7]     : req_y0[6:0];
  assign sel_y1    = sel ? req_y1[13:7]     : req_y1[6:0];
  assign sel_color = sel ? req_color[31:16] : req_color[15:0];

  assign bad = (sel_x0 > sel_x1) | (sel_y0 > sel_y1) |
               (32'(sel_x1) >= C_x_size) | (32'(sel_y1) >= C_y_size);

  assign hs       = tx_valid & tx_ready;
  assign last_arg = (idx_q == 3'd4);

  assign xs     = 16'(x0_q) + 16'(C_x_offset);
  assign xe     = 16'(x1_q) + 16'(C_x_offset);
  assign ys     = 16'(y0_q) + 16'(C_y_offset);
  assign ye     = 16'(y1_q) + 16'(C_y_offset);
  assign w0     = (state_q == StCaset) ? xs : ys;
  assign w1     = (state_q == StCaset) ? xe : ye;
  assign width  = 14'(x1_q) - 14'(x0_q) + 14'd1;
  assign height = 14'(y1_q) - 14'(y0_q) + 14'd1;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (acc) state_d = bad ? StErr : StCaset;
      StCaset: if (hs && last_arg) state_d = StRaset;
      StRaset: if (hs && last_arg) state_d = StRamwr;
      StRamwr: if (hs) state_d = StPixel;
      StPixel: if (hs && lo_q && (pix_q == 14'd0)) state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_dc    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      StCaset, StRaset: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_dc    = (idx_q != 3'd0);
        case (idx_q)
          3'd0:    tx_data = (state_q == StCaset) ? CmdCaset : CmdRaset;
          3'd1:    tx_data = w0[15:8];
          3'd2:    tx_data = w0[7:0];
          3'd3:    tx_data = w1[15:8];
          3'd4:    tx_data = w1[7:0];
          default: tx_data = 8'h00;
        endcase
      end
      StRamwr: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = CmdRamwr;
      end
      StPixel: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = lo_q ? color_q[7:0] : color_q[15:8];
      end
      StDone:  done = 1'b1;
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

  assign done_id = id_q;

  always_comb begin
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    id_d    = id_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    lo_d    = lo_q;
    if (acc) begin
      x0_d    = sel_x0;
      x1_d    = sel_x1;
      y0_d    = sel_y0;
      y1_d    = sel_y1;
      color_d = sel_color;
      id_d    = sel;
      idx_d   = 3'd0;
    end
    if (((state_q == StCaset) || (state_q == StRaset)) && hs) begin
      idx_d = last_arg ? 3'd0 : idx_q + 3'd1;
    end
    // Pixel count is loaded while RAMWR waits so PIXEL can start without a bubble.
    if (state_q == StRamwr) begin
      pix_d = width * height - 14'd1;
      lo_d  = 1'b0;
    end
    if ((state_q == StPixel) && hs) begin
      lo_d = ~lo_q;
      if (lo_q) pix_d = pix_q - 14'd1;
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      id_q    <= 1'b0;
      idx_q   <= '0;
      pix_q   <= '0;
      lo_q    <= 1'b0;
    end else begin
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_oled_rect_sched.sv
// Directed bench for oled_rect_sched: byte streams, arbitration, rejects, stalls and reset abort.
module tb_oled_rect_sched;

  logic        clk, resn, init_done, tx_ready;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_x0, req_x1;
  logic [13:0] req_y0, req_y1;
  logic [31:0] req_color;
  logic        tx_valid, tx_dc, busy, done, done_id, err;
  logic [7:0]  tx_data;

  int total = 0;
  int bad = 0;

  logic [8:0] q[$];
  int vcount = 0;
  int done_cnt = 0;
  int stall_seen = 0;
  int stall_bad = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;

  oled_rect_sched dut (
    .clk       (clk),
    .resn      (resn),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_y0    (req_y0),
    .req_y1    (req_y1),
    .req_color (req_color),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_dc     (tx_dc),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observer: records handshaken bytes and watches stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) q.push_back({tx_dc, tx_data});
      if (tx_valid) vcount++;
      if (done) done_cnt++;
      if (prev_stall) begin
        stall_seen++;
        if (!tx_valid || ({tx_dc, tx_data} != prev_byte)) stall_bad++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = {tx_dc, tx_data};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] x0, input logic [7:0] x1,
                         input logic [6:0] y0, input logic [6:0] y1, input logic [15:0] col);
    req_x0[8*id +: 8]     = x0;
    req_x1[8*id +: 8]     = x1;
    req_y0[7*id +: 7]     = y0;
    req_y1[7*id +: 7]     = y1;
    req_color[16*id +: 16] = col;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 resn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resn = 1'b1;
  endtask

  task automatic wait_rdy(output logic [1:0] r);
    int n;
    n = 0;
    r = 2'b00;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (req_ready != 2'b00) begin
        r = req_ready;
        break;
      end
    end
    if (r == 2'b00) check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int id);
    logic [1:0] r;
    req_valid[id] = 1'b1;
    wait_rdy(r);
    check("accept", {30'd0, r}, 32'(1 << id));
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_end(input bit tog, output bit d, output bit e, output bit id,
                          output int cyc);
    d = 1'b0;
    e = 1'b0;
    id = 1'b0;
    cyc = 0;
    while (cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (done || err) begin
        d = done;
        e = err;
        id = done_id;
        break;
      end
      if (tog) begin
        @(posedge clk);
        #1 tx_ready = ~tx_ready;
      end
    end
    if (!d && !e) check("end_timeout", 0, 1);
  endtask

  logic [8:0] exp1 [13];
  logic [1:0] r;
  bit d, e, id;
  int cyc, n0, d0, rdy_seen, pix_bad;
  logic [8:0] got;

  initial begin
    exp1 = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100, 9'h100, 9'h100,
             9'h100, 9'h02C, 9'h1F8, 9'h100};
    resn = 1'b0;
    init_done = 1'b1;
    tx_ready = 1'b1;
    req_valid = 2'b11;
    req_x0 = '0;
    req_x1 = '0;
    req_y0 = '0;
    req_y1 = '0;
    req_color = '0;

    // Reset state, with requests pending to show req_ready stays low.
    repeat (2) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_dc", tx_dc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_done_id", done_id, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 resn = 1'b1;

    // 1x1 rectangle from requester 0.
    set_req(0, 8'd0, 8'd0, 7'd0, 7'd0, 16'hF800);
    q.delete();
    send(0);
    @(negedge clk);
    check("first_valid", tx_valid, 1);
    check("first_byte", {tx_dc, tx_data}, 9'h02A);
    check("first_busy", busy, 1);
    wait_end(1'b0, d, e, id, cyc);
    check("r1_done", d, 1);
    check("r1_done_id", id, 0);
    check("r1_count", q.size(), 13);
    for (int i = 0; i < 13; i++) begin
      got = (i < q.size()) ? q[i] : 9'h1FF;
      check($sformatf("r1_byte%0d", i), got, exp1[i]);
    end
    @(negedge clk);
    check("r1_idle_valid", tx_valid, 0);

    // Round-robin on simultaneous requests.
    do_reset();
    set_req(0, 8'd0, 8'd0, 7'd0, 7'd0, 16'h1111);
    set_req(1, 8'd1, 8'd1, 7'd1, 7'd1, 16'h2222);
    req_valid = 2'b11;
    wait_rdy(r);
    check("tie_first", r, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_end(1'b0, d, e, id, cyc);
    check("tie_first_id", id, 0);
    wait_rdy(r);
    check("tie_second", r, 2'b10);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_end(1'b0, d, e, id, cyc);
    check("tie_second_id", id, 1);
    req_valid = 2'b11;
    wait_rdy(r);
    check("tie_third", r, 2'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_end(1'b0, d, e, id, cyc);
    wait_rdy(r);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_end(1'b0, d, e, id, cyc);

    // Inverted columns from requester 1 are rejected.
    set_req(1, 8'd10, 8'd5, 7'd0, 7'd0, 16'hFFFF);
    vcount = 0;
    send(1);
    wait_end(1'b0, d, e, id, cyc);
    check("rej_err", e, 1);
    check("rej_done", d, 0);
    check("rej_id", id, 1);
    check("rej_latency", cyc, 1);
    check("rej_no_tx", vcount, 0);

    // Full screen with tx_ready toggling every cycle.
    set_req(0, 8'd0, 8'd159, 7'd0, 7'd79, 16'h1234);
    tx_ready = 1'b1;
    stall_seen = 0;
    stall_bad = 0;
    q.delete();
    send(0);
    wait_end(1'b1, d, e, id, cyc);
    check("fs_done", d, 1);
    check("fs_bytes", q.size(), 25611);
    check("fs_pixel_bytes", q.size() - 11, 25600);
    got = (q.size() > 9) ? q[4] : 9'h000;
    check("fs_x1_lo", got, 9'h19F);
    got = (q.size() > 9) ? q[9] : 9'h000;
    check("fs_y1_lo", got, 9'h14F);
    pix_bad = 0;
    for (int i = 11; i < q.size(); i++) begin
      if (q[i] != (((i % 2) == 1) ? 9'h112 : 9'h134)) pix_bad++;
    end
    check("fs_pixel_data", pix_bad, 0);
    check("fs_stall_seen", (stall_seen > 1000), 1);
    check("fs_stall_stable", stall_bad, 0);
    tx_ready = 1'b1;

    // Reset in the middle of PIXEL aborts the rectangle.
    set_req(0, 8'd0, 8'd9, 7'd0, 7'd9, 16'hABCD);
    q.delete();
    send(0);
    n0 = 0;
    while ((q.size() < 15) && (n0 < 100)) begin
      @(negedge clk);
      n0++;
    end
    check("abort_in_pixel", (q.size() >= 15), 1);
    resn = 1'b0;
    #1;
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    n0 = q.size();
    d0 = done_cnt;
    @(posedge clk);
    #1 resn = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_bytes", q.size(), n0);
    check("abort_no_done", done_cnt, d0);
    set_req(0, 8'd3, 8'd3, 7'd2, 7'd2, 16'h0F0F);
    send(0);
    @(negedge clk);
    check("after_abort_byte", {tx_dc, tx_data}, 9'h02A);
    wait_end(1'b0, d, e, id, cyc);
    check("after_abort_done", d, 1);

    // init_done low holds off acceptance; dropping it mid-rectangle is ignored.
    init_done = 1'b0;
    set_req(0, 8'd1, 8'd2, 7'd1, 7'd1, 16'h5555);
    req_valid[0] = 1'b1;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_ready != 2'b00) rdy_seen++;
    end
    check("init_hold", rdy_seen, 0);
    check("init_hold_busy", busy, 0);
    @(posedge clk);
    #1 init_done = 1'b1;
    @(negedge clk);
    check("init_accept", req_ready, 2'b01);
    @(posedge clk);
    #1 begin
      req_valid[0] = 1'b0;
      init_done = 1'b0;
    end
    @(negedge clk);
    check("init_first_byte", {tx_dc, tx_data}, 9'h02A);
    q.delete();
    wait_end(1'b0, d, e, id, cyc);
    check("init_drop_done", d, 1);
    check("init_drop_bytes", q.size(), 14);
    init_done = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
